rf_shadow_checker: RTL

Parametrised register-file monitor that keeps a shadow copy of every architectural register from the observed write port(s). Every read port is checked against the shadow each cycle. Mismatches are counted, the first one is captured for debug, and illegal accesses and DUT-reported write-enable faults are flagged. Sits beside the register file in RF test benches and FPGA debug builds; all DUT-facing ports are inputs only.

---
 rtl/rf_shadow_checker.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/rf_shadow_checker.sv
// rf_shadow_checker: shadow-copy register-file monitor with read checking and first-mismatch capture.
// Optional macro RF_SHADOW_WRCOV_EN adds a written bitmap and the rbw_o read-before-write pulse.
module rf_shadow_checker #(
  parameter int                   DataWidth    = 32,
  parameter int                   NumRegs      = 32,
  parameter int                   NumReadPorts = 2,
  parameter int                   CntWidth     = 16,
  parameter logic [DataWidth-1:0] WordZeroVal  = '0,
  localparam int                  PortW        = (NumReadPorts > 1) ? $clog2(NumReadPorts) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           chk_en_i,
  input  logic                           clear_i,
  input  logic [NumReadPorts*5-1:0]      raddr_i,
  input  logic [NumReadPorts*DataWidth-1:0] rdata_i,
  input  logic [4:0]                     waddr_i,
  input  logic [DataWidth-1:0]           wdata_i,
  input  logic                           we_i,
  input  logic                           dut_err_i,
  output logic                           mismatch_o,
  output logic                           illegal_o,
  output logic                           sticky_err_o,
  output logic [CntWidth-1:0]            err_cnt_o,
  output logic                           cap_valid_o,
  output logic [PortW-1:0]               cap_port_o,
  output logic [4:0]                     cap_addr_o,
  output logic [DataWidth-1:0]           cap_exp_o,
`ifdef RF_SHADOW_WRCOV_EN
  output logic                           rbw_o,
`endif
  output logic [DataWidth-1:0]           cap_act_o
);

  typedef enum logic {IDLE, CAPT} cap_state_e;

  localparam int EvW  = 4;
  localparam int SumW = CntWidth + EvW;

  // Entries 0 and >= NumRegs are never written, so they hold WordZeroVal forever.
  logic [DataWidth-1:0] shadow_q [32];

  logic [4:0]           rd_addr  [NumReadPorts];
  logic [DataWidth-1:0] rd_data  [NumReadPorts];
  logic [DataWidth-1:0] exp_val  [NumReadPorts];
  logic [NumReadPorts-1:0] rd_legal;
  logic [NumReadPorts-1:0] rd_mism;
  logic                 rd_illegal;

  logic wr_legal;
  logic wr_ok;
  logic wr_illegal;
  logic illegal_now;
  logic any_mism;
  logic any_event;

  logic [EvW-1:0]      ev_cnt;
  logic [CntWidth-1:0] cnt_base;
  logic [SumW-1:0]     cnt_sum;
  logic [CntWidth-1:0] cnt_d;
  logic [PortW-1:0]    first_port;
  logic                first_found;
  logic [4:0]          first_addr;
  logic [DataWidth-1:0] first_exp;
  logic [DataWidth-1:0] first_act;

  cap_state_e state_q, state_d;
  logic       cap_load;

  logic                 mismatch_q;
  logic                 illegal_q;
  logic                 sticky_q;
  logic [CntWidth-1:0]  cnt_q;
  logic [PortW-1:0]     cap_port_q;
  logic [4:0]           cap_addr_q;
  logic [DataWidth-1:0] cap_exp_q;
  logic [DataWidth-1:0] cap_act_q;
  logic                 rbw_now;

  assign wr_legal   = int'(waddr_i) < NumRegs;
  assign wr_ok      = we_i && wr_legal && (waddr_i != 5'd0);
  assign wr_illegal = we_i && !wr_legal;

  // Per-port compare against the pre-write shadow value (no forwarding).
  always_comb begin
    rd_illegal = 1'b0;
    for (int p = 0; p < NumReadPorts; p++) begin
      rd_addr[p]  = raddr_i[5*p +: 5];
      rd_data[p]  = rdata_i[DataWidth*p +: DataWidth];
      exp_val[p]  = shadow_q[rd_addr[p]];
      rd_legal[p] = int'(rd_addr[p]) < NumRegs;
      rd_mism[p]  = chk_en_i && rd_legal[p] && (rd_data[p] != exp_val[p]);
      if (chk_en_i && !rd_legal[p]) begin
        rd_illegal = 1'b1;
      end
    end
  end

  assign illegal_now = rd_illegal || wr_illegal;
  assign any_mism    = |rd_mism;
  assign any_event   = any_mism || illegal_now || dut_err_i;

  always_comb begin
    first_port  = '0;
    first_found = 1'b0;
    first_addr  = '0;
    first_exp   = '0;
    first_act   = '0;
    for (int p = 0; p < NumReadPorts; p++) begin
      if (rd_mism[p] && !first_found) begin
        first_found = 1'b1;
        first_port  = PortW'(p);
        first_addr  = rd_addr[p];
        first_exp   = exp_val[p];
        first_act   = rd_data[p];
      end
    end
  end

  // Clear zeroes the counter before this cycle's events are added; the sum saturates.
  always_comb begin
    ev_cnt = '0;
    for (int p = 0; p < NumReadPorts; p++) begin
      ev_cnt = ev_cnt + EvW'(rd_mism[p]);
    end
    ev_cnt   = ev_cnt + EvW'(illegal_now) + EvW'(dut_err_i);
    cnt_base = clear_i ? '0 : cnt_q;
    cnt_sum  = SumW'(cnt_base) + SumW'(ev_cnt);
    if (cnt_sum > SumW'({CntWidth{1'b1}})) begin
      cnt_d = {CntWidth{1'b1}};
    end else begin
      cnt_d = cnt_sum[CntWidth-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    cap_load = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
    end
    if ((clear_i || state_q == IDLE) && any_mism) begin
      state_d  = CAPT;
      cap_load = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cap_port_q <= '0;
      cap_addr_q <= '0;
      cap_exp_q  <= '0;
      cap_act_q  <= '0;
    end else if (cap_load) begin
      cap_port_q <= first_port;
      cap_addr_q <= first_addr;
      cap_exp_q  <= first_exp;
      cap_act_q  <= first_act;
    end else if (clear_i) begin
      cap_port_q <= '0;
      cap_addr_q <= '0;
      cap_exp_q  <= '0;
      cap_act_q  <= '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < 32; r++) begin
        shadow_q[r] <= WordZeroVal;
      end
    end else if (wr_ok) begin
      shadow_q[waddr_i] <= wdata_i;
    end
  end

`ifdef RF_SHADOW_WRCOV_EN
  logic [31:0] written_q;
  logic        rbw_q;

  always_comb begin
    rbw_now = 1'b0;
    for (int p = 0; p < NumReadPorts; p++) begin
      if (chk_en_i && rd_legal[p] && (rd_addr[p] != 5'd0) && !written_q[rd_addr[p]]) begin
        rbw_now = 1'b1;
      end
    end
  end

  // The bitmap survives clear_i; only reset forgets which registers were written.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      written_q <= '0;
      rbw_q     <= 1'b0;
    end else begin
      rbw_q <= rbw_now;
      if (wr_ok) begin
        written_q[waddr_i] <= 1'b1;
      end
    end
  end

  assign rbw_o = rbw_q;
`else
  assign rbw_now = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mismatch_q <= 1'b0;
      illegal_q  <= 1'b0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      mismatch_q <= any_mism;
      illegal_q  <= illegal_now;
      sticky_q   <= (sticky_q && !clear_i) || any_event || rbw_now;
      cnt_q      <= cnt_d;
    end
  end

  assign mismatch_o   = mismatch_q;
  assign illegal_o    = illegal_q;
  assign sticky_err_o = sticky_q;
  assign err_cnt_o    = cnt_q;
  assign cap_valid_o  = (state_q == CAPT);
  assign cap_port_o   = cap_port_q;
  assign cap_addr_o   = cap_addr_q;
  assign cap_exp_o    = cap_exp_q;
  assign cap_act_o    = cap_act_q;

endmodule
